// File: rtl/spike_rate_decoder.sv
// Rate decoder: counts upstream spikes over a fixed window of clock cycles and
// presents each window's saturated count through a valid/ready output register.
module spike_rate_decoder #(
    parameter int unsigned data_bits = 4,
    parameter int unsigned window    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spike_in,
    input  logic                 enable,
    output logic [data_bits-1:0] data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sat,
    output logic                 overrun
);

    localparam int unsigned CW = (window > 1) ? $clog2(window) : 1;
    localparam logic [CW-1:0]        LAST_IDX = CW'(window - 1);
    localparam logic [data_bits-1:0] CNT_MAX  = '1;

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        win_cnt, win_cnt_nxt;
    logic [data_bits-1:0] spike_cnt, spike_cnt_nxt;
    logic                 sat_acc, sat_acc_nxt;
    logic [data_bits-1:0] data_nxt;
    logic                 valid_nxt;
    logic                 sat_nxt;
    logic                 overrun_nxt;
    logic                 complete_c;
    logic                 cnt_full_c;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            win_cnt   <= '0;
            spike_cnt <= '0;
            sat_acc   <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            win_cnt   <= win_cnt_nxt;
            spike_cnt <= spike_cnt_nxt;
            sat_acc   <= sat_acc_nxt;
            data_out  <= data_nxt;
            out_valid <= valid_nxt;
            sat       <= sat_nxt;
            overrun   <= overrun_nxt;
        end
    end

    assign cnt_full_c = (spike_cnt == CNT_MAX);

    // Next-state: window integration plus result/handshake update
    always_comb begin
        state_nxt     = state;
        win_cnt_nxt   = win_cnt;
        spike_cnt_nxt = spike_cnt;
        sat_acc_nxt   = sat_acc;
        data_nxt      = data_out;
        valid_nxt     = out_valid;
        sat_nxt       = sat;
        overrun_nxt   = 1'b0;
        complete_c    = 1'b0;

        case (state)
            IDLE: begin
                win_cnt_nxt   = '0;
                spike_cnt_nxt = '0;
                sat_acc_nxt   = 1'b0;
                if (enable) begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (!enable) begin
                    // Abort discards the partial window without producing a result
                    state_nxt     = IDLE;
                    win_cnt_nxt   = '0;
                    spike_cnt_nxt = '0;
                    sat_acc_nxt   = 1'b0;
                end else if (win_cnt == LAST_IDX) begin
                    complete_c    = 1'b1;
                    win_cnt_nxt   = '0;
                    spike_cnt_nxt = '0;
                    sat_acc_nxt   = 1'b0;
                end else begin
                    win_cnt_nxt = win_cnt + CW'(1);
                    if (spike_in) begin
                        if (cnt_full_c) begin
                            sat_acc_nxt = 1'b1;
                        end else begin
                            spike_cnt_nxt = spike_cnt + data_bits'(1);
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (complete_c) begin
            data_nxt    = (spike_in && !cnt_full_c) ? spike_cnt + data_bits'(1) : spike_cnt;
            sat_nxt     = sat_acc | (spike_in & cnt_full_c);
            valid_nxt   = 1'b1;
            overrun_nxt = out_valid & ~out_ready;
        end else if (out_valid && out_ready) begin
            valid_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: directed window table, corner-case
// sequences and random traffic, all checked against a window-level reference model.
module tb_spike_rate_decoder;

    localparam int unsigned DB  = 4;
    localparam int unsigned WIN = 16;
    localparam int          MAXC = (1 << DB) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          spike_in = 1'b0;
    logic          enable = 1'b0;
    logic          out_ready = 1'b0;
    logic [DB-1:0] data_out;
    logic          out_valid;
    logic          sat;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    spike_rate_decoder #(.data_bits(DB), .window(WIN)) dut (
        .clk       (clk),
        .rst       (rst),
        .spike_in  (spike_in),
        .enable    (enable),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat       (sat),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: collects the samples of the running window in a queue
    bit m_active;
    bit samples[$];
    int m_data;
    bit m_valid, m_sat, m_ovr;

    task automatic model_edge(input bit r, input bit e, input bit s, input bit y);
        bit done = 0;
        int ones = 0;
        if (r) begin
            m_active = 0; samples.delete();
            m_data = 0; m_valid = 0; m_sat = 0; m_ovr = 0;
            return;
        end
        if (m_active && !e) begin
            m_active = 0;
            samples.delete();
        end else if (m_active) begin
            samples.push_back(s);
            if (samples.size() == WIN) begin
                foreach (samples[k]) ones += int'(samples[k]);
                samples.delete();
                done = 1;
            end
        end else if (e) begin
            m_active = 1;
        end
        m_ovr = done && m_valid && !y;
        if (done) begin
            m_data  = (ones > MAXC) ? MAXC : ones;
            m_sat   = (ones > MAXC);
            m_valid = 1;
        end else if (m_valid && y) begin
            m_valid = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock: drive, advance model, then sample 1 time unit after the edge
    task automatic step(input bit r, input bit e, input bit s, input bit y);
        rst = r; enable = e; spike_in = s; out_ready = y;
        model_edge(r, e, s, y);
        @(posedge clk);
        #1;
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("data_out",  int'(data_out),  m_data);
        chk("sat",       int'(sat),       int'(m_sat));
        chk("overrun",   int'(overrun),   int'(m_ovr));
    endtask

    task automatic run_window(input logic [WIN-1:0] pat, input bit rdy, input bit rdy_last);
        for (int i = 0; i < WIN; i++)
            step(0, 1, pat[i], (i == WIN - 1) ? rdy_last : rdy);
    endtask

    typedef struct {
        logic [WIN-1:0] pat;
        int             exp_data;
        bit             exp_sat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{16'b0000_0100_1010_0011, 5,  1'b0};
        vecs[1] = '{16'hFFFF,                15, 1'b1};
        vecs[2] = '{16'h0000,                0,  1'b0};
        vecs[3] = '{16'h7FFF,                15, 1'b0};
        vecs[4] = '{16'hAAAA,                8,  1'b0};
        vecs[5] = '{16'h8001,                2,  1'b0};

        step(1, 1, 1, 1);
        step(1, 0, 0, 0);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_data",  int'(data_out),  0);
        chk("reset_sat",   int'(sat),       0);

        // Idle ignores spikes; entering COUNT takes one edge
        step(0, 0, 1, 1);
        step(0, 1, 1, 1);

        // Directed window table, consumer always ready
        foreach (vecs[v]) begin
            run_window(vecs[v].pat, 1, 1);
            chk("tbl_valid", int'(out_valid), 1);
            chk("tbl_data",  int'(data_out),  vecs[v].exp_data);
            chk("tbl_sat",   int'(sat),       int'(vecs[v].exp_sat));
        end
        step(0, 1, 0, 1);
        chk("one_cycle_valid", int'(out_valid), 0);
        for (int i = 1; i < WIN; i++) step(0, 1, 0, 1);

        // Backpressure across two windows: 3 spikes then 7 spikes
        run_window(16'h0111, 0, 0);
        chk("bp_first", int'(data_out), 3);
        for (int i = 0; i < WIN - 1; i++) begin
            step(0, 1, (i < 7), 0);
            chk("bp_hold", int'(data_out), 3);
        end
        step(0, 1, 0, 0);
        chk("bp_second", int'(data_out), 7);
        chk("bp_overrun", int'(overrun), 1);
        step(0, 1, 0, 1);
        chk("bp_pulse_end", int'(overrun), 0);
        chk("bp_accepted", int'(out_valid), 0);
        for (int i = 1; i < WIN; i++) step(0, 1, 0, 0);
        chk("bp_flush", int'(out_valid), 1);

        // Accept on the very edge a new window completes
        run_window(16'h0F00, 0, 1);
        chk("simul_valid", int'(out_valid), 1);
        chk("simul_data",  int'(data_out),  4);
        chk("simul_ovr",   int'(overrun),   0);
        step(0, 0, 0, 1);

        // Abort after 8 cycles with 4 spikes, then a fresh window with 2 spikes
        step(0, 1, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 1, i[0], 1);
        step(0, 0, 1, 1);
        chk("abort_noresult", int'(out_valid), 0);
        step(0, 1, 0, 1);
        run_window(16'h0042, 1, 1);
        chk("abort_next", int'(data_out), 2);

        // Reset at win_cnt=10 with a pending result
        run_window(16'h0003, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0);
        step(1, 1, 1, 1);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data",  int'(data_out),  0);
        chk("rst_sat",   int'(sat),       0);
        chk("rst_ovr",   int'(overrun),   0);
        step(0, 1, 1, 1);
        run_window(16'h0707, 1, 1);
        chk("rst_fresh", int'(data_out), 6);

        // Random traffic: moderate then dense spike rates
        for (int i = 0; i < 4000; i++) begin
            bit dense = (i >= 2000);
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 39) != 0,
                 dense ? ($urandom_range(0, 31) != 0) : ($urandom_range(0, 1) == 1),
                 $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 The block SHALL have parameter data_bits, default 4, setting the result width in bits.
REQ-002 The block SHALL have parameter window, default 16, setting the integration window length in clock cycles; legal range is 2 to 256.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port spike_in, input, 1 bit: spike line driven by the data_out of an upstream spiking neuron.
REQ-006 Port enable, input, 1 bit: 1 runs integration; 0 aborts the current window and idles the block.
REQ-007 Port data_out, output, data_bits bits: spike count of the last completed window, fed to the data_in of a downstream neuron.
REQ-008 Port out_valid, output, 1 bit: data_out holds an unconsumed result.
REQ-009 Port out_ready, input, 1 bit: the consumer accepts data_out.
REQ-010 Port sat, output, 1 bit: the result in data_out was clipped at 2^data_bits-1; qualified by out_valid.
REQ-011 Port overrun, output, 1 bit: one-cycle pulse when an unconsumed result is overwritten.

Function
REQ-012 The block SHALL have two states: IDLE and COUNT.
REQ-013 IDLE -> COUNT on a rising edge with enable=1; COUNT -> IDLE on a rising edge with enable=0.
REQ-014 In IDLE, win_cnt and spike_cnt SHALL be held at 0 and spike_in SHALL be ignored.
REQ-015 In COUNT, the block SHALL sample spike_in on every edge and increment win_cnt from 0 to window-1.
REQ-016 spike_cnt SHALL increment by 1 per sampled spike and saturate at 2^data_bits-1, with no wrap-around.
REQ-017 Sampling into a saturated spike_cnt SHALL set an internal sat_acc flag for the current window.
REQ-018 On the edge that samples with win_cnt=window-1, the block SHALL complete the window:
- data_out is loaded with the saturated value of spike_cnt plus the current spike_in;
- sat is loaded with sat_acc, or 1 if that final sample saturates;
- out_valid is set to 1;
- win_cnt, spike_cnt and sat_acc are cleared;
- the state stays COUNT.
REQ-019 Latency SHALL be 1 cycle: the result is visible in the cycle after the last sample of the window.
REQ-020 Consecutive windows SHALL be back-to-back, with no dead cycle between them.
REQ-021 A handshake transfer occurs on an edge where out_valid=1 and out_ready=1; out_valid SHALL then clear, unless a window completes on the same edge.
REQ-022 While out_valid=1 and out_ready=0, data_out and sat SHALL remain stable.
REQ-023 A window completing while out_valid=1 and out_ready=0 SHALL overwrite data_out and sat, keep out_valid=1, and pulse overrun for one cycle.
REQ-024 A window completing on the same edge as a transfer SHALL load the new result, keep out_valid=1, and not pulse overrun.
REQ-025 enable=0 mid-window SHALL discard the partial count and produce no result.
REQ-026 enable=0 SHALL NOT affect out_valid, data_out or sat; a pending result stays available to the handshake.
REQ-027 out_valid SHALL NOT depend combinationally on out_ready.

Reset
REQ-028 rst=1 on a rising edge SHALL set the state to IDLE and clear win_cnt, spike_cnt, sat_acc, data_out, out_valid, sat and overrun, at any point of operation.
REQ-029 rst SHALL take priority over enable, spike_in and out_ready.
REQ-030 After rst is released, the first window SHALL start on the first edge with enable=1.

Verification
REQ-031 Window count: defaults, out_ready=1, enable=1, spike_in high on 5 of 16 cycles -> data_out=5, sat=0, out_valid=1 for exactly one cycle, 1 cycle after the 16th sample.
REQ-032 Saturation: spike_in held at 1 for a full 16-cycle window -> data_out=15, sat=1; the next window with zero spikes -> data_out=0, sat=0.
REQ-033 Backpressure: out_ready=0 across two windows with 3 then 7 spikes -> data_out=3 stable for 16 cycles, then data_out=7 with a one-cycle overrun pulse; out_ready=1 -> out_valid clears next cycle.
REQ-034 Simultaneous accept: out_ready asserted on the exact edge a window completes -> new value loaded, out_valid stays 1, overrun=0.
REQ-035 Abort: enable dropped after 8 cycles with 4 spikes, then re-raised -> no result from the aborted window; the next full window with 2 spikes -> data_out=2.
REQ-036 Reset mid-operation: rst pulsed at win_cnt=10 while out_valid=1 -> next cycle all outputs 0 and state IDLE; enable=1 starts a fresh 16-cycle window.
